// File: rtl/cn_msg_gather.sv
// cn_msg_gather
//   Serial-to-parallel front end and parallel-to-serial back end for the
//   degree-DEG check node. Gathers DEG variable-to-check messages (one per
//   beat) onto cn_in_bus, captures cn_out_bus one cycle later, then streams
//   the DEG check-to-variable messages back out. One frame in flight at a time.
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   in_valid/in_ready        input handshake; in_msg + in_last per beat
//   cn_in_bus                gathered messages to cn, slice k = msg_in_(k+1)
//   cn_out_bus               cn results, same slicing
//   out_valid/out_ready      output handshake; out_msg + out_last per beat
//   err_len                  one-cycle pulse when a malformed frame is dropped
module cn_msg_gather #(
  parameter int unsigned MSG_W = 11,
  parameter int unsigned DEG   = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MSG_W-1:0]     in_msg,
  input  logic                 in_last,
  output logic [DEG*MSG_W-1:0] cn_in_bus,
  input  logic [DEG*MSG_W-1:0] cn_out_bus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MSG_W-1:0]     out_msg,
  output logic                 out_last,
  output logic                 err_len
);

  localparam int unsigned IDX_W = (DEG > 1) ? $clog2(DEG) : 1;

  typedef enum logic [1:0] {COLLECT, CAPTURE, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]     rd_nxt;
  logic [DEG*MSG_W-1:0] cn_in_bus_q, cn_in_bus_d;
  logic [DEG*MSG_W-1:0] cap_q, cap_d;
  logic [MSG_W-1:0]     out_msg_q, out_msg_d;
  logic                 out_last_q, out_last_d;
  logic                 err_len_q, err_len_d;
  logic                 in_fire, out_fire;
  logic                 wr_at_end, rd_at_end;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign wr_at_end = (wr_idx_q == IDX_W'(DEG - 1));
  assign rd_at_end = (rd_idx_q == IDX_W'(DEG - 1));
  assign rd_nxt    = rd_idx_q + IDX_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (in_fire && wr_at_end && in_last) state_d = CAPTURE;
      CAPTURE: state_d = DRAIN;
      DRAIN:   if (out_fire && rd_at_end) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Handshake outputs decode straight from the state register, so there is
  // no combinational path from in_valid to in_ready.
  always_comb begin
    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == DRAIN);
  end

  // Datapath
  always_comb begin
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    cn_in_bus_d = cn_in_bus_q;
    cap_d       = cap_q;
    out_msg_d   = out_msg_q;
    out_last_d  = out_last_q;
    err_len_d   = 1'b0;

    if (in_fire) begin
      for (int unsigned k = 0; k < DEG; k++) begin
        if (wr_idx_q == IDX_W'(k)) cn_in_bus_d[k*MSG_W +: MSG_W] = in_msg;
      end
      if (wr_at_end || in_last) begin
        wr_idx_d  = '0;
        // Short (last too early) or long (no last at final slot) frame.
        err_len_d = (wr_at_end != in_last);
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end

    if (state_q == CAPTURE) begin
      // out_msg is registered, so slice 0 is preloaded from cn directly
      // on the same edge that fills the capture registers.
      cap_d      = cn_out_bus;
      rd_idx_d   = '0;
      out_msg_d  = cn_out_bus[0 +: MSG_W];
      out_last_d = (DEG == 1);
    end

    if (out_fire) begin
      if (rd_at_end) begin
        rd_idx_d   = '0;
        out_msg_d  = '0;
        out_last_d = 1'b0;
      end else begin
        rd_idx_d   = rd_nxt;
        out_last_d = (rd_nxt == IDX_W'(DEG - 1));
        for (int unsigned k = 0; k < DEG; k++) begin
          if (rd_nxt == IDX_W'(k)) out_msg_d = cap_q[k*MSG_W +: MSG_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      cn_in_bus_q <= '0;
      cap_q       <= '0;
      out_msg_q   <= '0;
      out_last_q  <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      cn_in_bus_q <= cn_in_bus_d;
      cap_q       <= cap_d;
      out_msg_q   <= out_msg_d;
      out_last_q  <= out_last_d;
      err_len_q   <= err_len_d;
    end
  end

  assign cn_in_bus = cn_in_bus_q;
  assign out_msg   = out_msg_q;
  assign out_last  = out_last_q;
  assign err_len   = err_len_q;

endmodule
